cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port stall, input, 1, hazard hold from the decode-stage hazard logic.
REQ-004 SHALL have port branchTake, input, 1, redirect request from the decode stage.
REQ-005 SHALL have port pcBranch, input, 16, redirect target from the decode stage.
REQ-006 SHALL have port imemData, input, 16, combinational instruction memory read data for imemAddr.
REQ-007 SHALL have port imemAddr, output, 16, current PC driven to instruction memory.
REQ-008 SHALL have port instrOut, output, 16, IF/ID registered instruction.
REQ-009 SHALL have port pcOut, output, 16, IF/ID registered PC+2 of instrOut.
REQ-010 SHALL have port validOut, output, 1, IF/ID entry holds a real instruction, not a bubble.
REQ-011 SHALL have port halted, output, 1, HLT has been fetched and the PC is frozen.
REQ-012 SHALL have ports fetchCnt and stallCnt, output, 16 each, present only under IF_PERF_CNT_EN.

Function
REQ-013 SHALL drive imemAddr combinationally from the PC register, with no added latency.
REQ-014 SHALL, on an edge with stall=1, hold PC, instrOut, pcOut, validOut and halted unchanged, ignoring branchTake on that edge.
REQ-015 SHALL, on an edge with stall=0 and branchTake=1, load PC with pcBranch, load instrOut with 16'h0000, set validOut=0 and clear halted.
REQ-016 SHALL, on an edge with stall=0, branchTake=0 and halted=0, load instrOut with imemData, pcOut with PC+2 and validOut=1.
REQ-017 SHALL, on the same edge as REQ-016, advance PC to PC+2 (mod 2^16, 16'hFFFE wraps to 16'h0000) unless imemData[15:12]==4'hF.
REQ-018 SHALL, when the fetched opcode is 4'hF (HLT), keep PC at the HLT address, still latch the HLT into IF/ID with validOut=1, and set halted=1.
REQ-019 SHALL, while halted=1 and no redirect occurs, insert bubbles (instrOut=16'h0000, validOut=0) and hold the PC.
REQ-020 SHALL ignore PC bit 0; pcBranch is used as given, with no alignment correction.
REQ-021 SHALL give priority stall > branchTake > HLT detect > sequential fetch.

Reset
REQ-022 SHALL, while rst_n=0 and independent of clk, force PC=16'h0000, instrOut=16'h0000, pcOut=16'h0000, validOut=0, halted=0, and any counters=0.
REQ-023 SHALL, on the first edge after rst_n rises, perform a normal fetch from address 16'h0000.
REQ-024 SHALL, when reset asserts mid-stall or mid-halt, discard that condition completely.

Configuration
REQ-025 SHALL compile performance counters only when macro IF_PERF_CNT_EN is defined.
REQ-026 SHALL, with IF_PERF_CNT_EN defined, increment fetchCnt on each REQ-016 load and stallCnt on each edge with stall=1; both counters saturate at 16'hFFFF.
REQ-027 SHALL, without IF_PERF_CNT_EN, omit fetchCnt, stallCnt and their logic entirely, leaving all other behaviour identical.

Verification
REQ-028 SHALL cover reset then sequential fetch: imem[0]=16'h1234, imem[2]=16'h5678 -> after edge 1: instrOut=16'h1234, pcOut=16'h0002, validOut=1; after edge 2: instrOut=16'h5678, pcOut=16'h0004.
REQ-029 SHALL cover stall: stall=1 for 3 edges at PC=16'h0004 -> imemAddr=16'h0004 and IF/ID unchanged throughout; stallCnt=3 with IF_PERF_CNT_EN.
REQ-030 SHALL cover redirect: branchTake=1, pcBranch=16'h0040 -> next cycle: imemAddr=16'h0040, instrOut=16'h0000, validOut=0; the edge after fetches imem[16'h0040].
REQ-031 SHALL cover halt: imem[16'h0006]=16'hF000 -> HLT latched with validOut=1, halted=1, PC held at 16'h0006, bubbles thereafter; a later branchTake to 16'h0010 clears halted.
REQ-032 SHALL cover conflicts: stall=1 with branchTake=1 -> PC unchanged; PC=16'hFFFE sequential -> wraps to 16'h0000, pcOut=16'h0000.
REQ-033 SHALL cover async reset: rst_n pulsed low between clock edges while halted -> all outputs reset immediately, and fetch resumes from 16'h0000.

Source files
------------

// File: rtl/cpu_fetch.sv
// ---------------------------------------------------------------------------
// cpu_fetch -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the program counter and drives it straight to instruction memory.
// The memory answers combinationally. Each unstalled edge does one of three
// things: it takes a decode-stage redirect, it inserts a bubble while halted,
// or it latches the fetched word into IF/ID. Fetching an HLT (opcode 4'hF)
// freezes the PC on the HLT address until the next redirect.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   stall      : hazard hold; freezes PC and IF/ID (has priority over redirect)
//   branchTake : redirect request from decode
//   pcBranch   : redirect target, used as given (bit 0 is not corrected)
//   imemData   : instruction memory read data for imemAddr
//   imemAddr   : current PC
//   instrOut   : IF/ID instruction (16'h0000 for a bubble)
//   pcOut      : IF/ID PC+2 of instrOut
//   validOut   : IF/ID holds a real instruction
//   halted     : HLT fetched, PC frozen
//   fetchCnt   : number of instruction loads, saturating  (IF_PERF_CNT_EN only)
//   stallCnt   : number of stalled edges, saturating      (IF_PERF_CNT_EN only)
//
// Build option
//   IF_PERF_CNT_EN : when defined, adds fetchCnt/stallCnt and their counters.
// ---------------------------------------------------------------------------
module cpu_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTake,
    input  logic [15:0] pcBranch,
    input  logic [15:0] imemData,
    output logic [15:0] imemAddr,
    output logic [15:0] instrOut,
    output logic [15:0] pcOut,
    output logic        validOut,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] fetchCnt,
    output logic [15:0] stallCnt
`endif
);

    localparam logic [3:0] OPC_HLT = 4'hF;

    logic [15:0] pc_q,     pc_d;
    logic [15:0] instr_q,  instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q,  valid_d;
    logic        halted_q, halted_d;

    logic [15:0] pc_plus2;
    logic        fetch_en;
    logic        is_hlt;

    assign pc_plus2 = pc_q + 16'd2;   // wraps naturally from 16'hFFFE to 16'h0000
    assign is_hlt   = (imemData[15:12] == OPC_HLT);
    // A real fetch happens only when nothing of higher priority claims the edge.
    assign fetch_en = !stall && !branchTake && !halted_q;

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (stall) begin
            // Hold everything. A redirect arriving on this edge is dropped;
            // decode re-presents it once the hazard clears.
        end else if (branchTake) begin
            pc_d     = pcBranch;
            instr_d  = 16'h0000;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end else if (halted_q) begin
            instr_d  = 16'h0000;
            valid_d  = 1'b0;
        end else begin
            instr_d  = imemData;
            pc_out_d = pc_plus2;
            valid_d  = 1'b1;
            // The HLT itself still goes down the pipe. The PC stays on it.
            if (is_hlt) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= 16'h0000;
            instr_q  <= 16'h0000;
            pc_out_q <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imemAddr = pc_q;
    assign instrOut = instr_q;
    assign pcOut    = pc_out_q;
    assign validOut = valid_q;
    assign halted   = halted_q;

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_en && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetchCnt = fetch_cnt_q;
    assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// ---------------------------------------------------------------------------
// tb_cpu_fetch -- self-checking bench for cpu_fetch.
// Part 1 applies a directed vector table and checks it against hand-computed
// expectations. Part 2 pulses an asynchronous reset while the fetch stage is
// halted. Part 3 drives random traffic and checks it against a behavioural
// model. Counter checks are compiled in only when IF_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branchTake = 1'b0;
    logic [15:0] pcBranch = 16'h0000;
    logic [15:0] imemData;
    logic [15:0] imemAddr, instrOut, pcOut;
    logic        validOut, halted;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetchCnt, stallCnt;
`endif

    logic [15:0] imem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, written from the fetch rules themselves
    int m_pc, m_instr, m_pcout, m_fc, m_sc;
    bit m_valid, m_halted;

    always #5 clk = ~clk;

    assign imemData = imem[imemAddr];

    cpu_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branchTake (branchTake),
        .pcBranch   (pcBranch),
        .imemData   (imemData),
        .imemAddr   (imemAddr),
        .instrOut   (instrOut),
        .pcOut      (pcOut),
        .validOut   (validOut),
        .halted     (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .fetchCnt   (fetchCnt),
        .stallCnt   (stallCnt)
`endif
    );

    typedef struct {
        bit        s;
        bit        b;
        logic [15:0] t;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        bit        e_valid;
        bit        e_halt;
        bit        chk_pc;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0; m_halted = 0;
        m_fc = 0; m_sc = 0;
    endtask

    // One clock edge of the fetch stage, evaluated from the rules.
    task automatic model_step(input bit s, input bit b, input int t);
        int word;
        if (s) begin
            m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
        end else if (b) begin
            m_pc = t; m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_instr = 0; m_valid = 0;
        end else begin
            word    = int'(imem[m_pc]);
            m_instr = word;
            m_pcout = (m_pc + 2) % 65536;
            m_valid = 1;
            m_fc    = (m_fc < 65535) ? m_fc + 1 : 65535;
            if (word / 4096 == 15) m_halted = 1;
            else                   m_pc = (m_pc + 2) % 65536;
        end
    endtask

    task automatic cycle(input bit s, input bit b, input logic [15:0] t);
        stall = s; branchTake = b; pcBranch = t;
        model_step(s, b, int'(t));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_addr"},   imemAddr, 16'(m_pc));
        chk({tag, "_instr"},  instrOut, 16'(m_instr));
        chk({tag, "_valid"},  16'(validOut), 16'(m_valid));
        chk({tag, "_halted"}, 16'(halted), 16'(m_halted));
        if (m_valid) chk({tag, "_pcout"}, pcOut, 16'(m_pcout));
`ifdef IF_PERF_CNT_EN
        chk({tag, "_fcnt"}, fetchCnt, 16'(m_fc));
        chk({tag, "_scnt"}, stallCnt, 16'(m_sc));
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},   imemAddr, 16'h0000);
        chk({tag, "_instr"},  instrOut, 16'h0000);
        chk({tag, "_pcout"},  pcOut, 16'h0000);
        chk({tag, "_valid"},  16'(validOut), 16'h0000);
        chk({tag, "_halted"}, 16'(halted), 16'h0000);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_fcnt"}, fetchCnt, 16'h0000);
        chk({tag, "_scnt"}, stallCnt, 16'h0000);
`endif
    endtask

    initial begin
        logic [15:0] w;

        for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
        imem[16'h0000] = 16'h1234;
        imem[16'h0002] = 16'h5678;
        imem[16'h0004] = 16'h2222;
        imem[16'h0006] = 16'hF000;
        imem[16'h0010] = 16'h3333;
        imem[16'h0040] = 16'hABCD;
        imem[16'hFFFE] = 16'h4444;

        //          s  b  target    addr      instr     pcOut    v  h  chkpc
        vecs[0]  = '{0, 0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1, 0, 1};
        vecs[1]  = '{0, 0, 16'h0000, 16'h0004, 16'h5678, 16'h0004, 1, 0, 1};
        vecs[2]  = '{1, 0, 16'h0000, 16'h0004, 16'h5678, 16'h0004, 1, 0, 1};
        vecs[3]  = '{1, 1, 16'h0080, 16'h0004, 16'h5678, 16'h0004, 1, 0, 1};
        vecs[4]  = '{1, 0, 16'h0000, 16'h0004, 16'h5678, 16'h0004, 1, 0, 1};
        vecs[5]  = '{0, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[6]  = '{0, 0, 16'h0000, 16'h0042, 16'hABCD, 16'h0042, 1, 0, 1};
        vecs[7]  = '{0, 1, 16'h0006, 16'h0006, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[8]  = '{0, 0, 16'h0000, 16'h0006, 16'hF000, 16'h0008, 1, 1, 1};
        vecs[9]  = '{0, 0, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[10] = '{1, 1, 16'h0020, 16'h0006, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[11] = '{0, 0, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[12] = '{0, 1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[13] = '{0, 0, 16'h0000, 16'h0012, 16'h3333, 16'h0012, 1, 0, 1};
        vecs[14] = '{0, 1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[15] = '{0, 0, 16'h0000, 16'h0000, 16'h4444, 16'h0000, 1, 0, 1};
        vecs[16] = '{0, 0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1, 0, 1};

        // Reset state
        model_reset();
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].s, vecs[i].b, vecs[i].t);
            chk($sformatf("v%0d_addr", i),   imemAddr, vecs[i].e_addr);
            chk($sformatf("v%0d_instr", i),  instrOut, vecs[i].e_instr);
            chk($sformatf("v%0d_valid", i),  16'(validOut), 16'(vecs[i].e_valid));
            chk($sformatf("v%0d_halted", i), 16'(halted), 16'(vecs[i].e_halt));
            if (vecs[i].chk_pc) chk($sformatf("v%0d_pcout", i), pcOut, vecs[i].e_pc);
`ifdef IF_PERF_CNT_EN
            if (i == 4) chk("stall_cnt_3", stallCnt, 16'd3);
            chk($sformatf("v%0d_fcnt", i), fetchCnt, 16'(m_fc));
            chk($sformatf("v%0d_scnt", i), stallCnt, 16'(m_sc));
`endif
            $display("vec %0d: s=%0d b=%0d t=%h -> addr=%h instr=%h pc=%h v=%0d h=%0d",
                     i, vecs[i].s, vecs[i].b, vecs[i].t, imemAddr, instrOut, pcOut,
                     validOut, halted);
        end

        // Asynchronous reset while halted
        cycle(1'b0, 1'b1, 16'h0006);
        cycle(1'b0, 1'b0, 16'h0000);
        chk("pre_rst_halted", 16'(halted), 16'h0001);
        stall = 1'b1;                      // also assert a stall across the reset
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("async_rst");
        #1 rst_n = 1'b1;
        stall = 1'b0;
        cycle(1'b0, 1'b0, 16'h0000);
        chk("post_rst_instr", instrOut, 16'h1234);
        chk("post_rst_pcout", pcOut, 16'h0002);
        chk("post_rst_valid", 16'(validOut), 16'h0001);
        chk("post_rst_addr",  imemAddr, 16'h0002);
        $display("async reset: addr=%h instr=%h pc=%h v=%0d h=%0d",
                 imemAddr, instrOut, pcOut, validOut, halted);

        // Random traffic against the model
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(7) != 0 && w[15:12] == 4'hF) w[15:12] = 4'h0;
            imem[i] = w;
        end
        for (int i = 0; i < 400; i++) begin
            logic [15:0] tgt;
            bit s, b;
            s   = ($urandom_range(3) == 0);
            b   = ($urandom_range(4) == 0);
            tgt = ($urandom_range(9) == 0) ? 16'($urandom) : (16'($urandom) & 16'hFFFE);
            cycle(s, b, tgt);
            chk_model($sformatf("rnd%0d", i));
            $display("rnd %0d: s=%0d b=%0d t=%h -> addr=%h instr=%h v=%0d h=%0d",
                     i, s, b, tgt, imemAddr, instrOut, validOut, halted);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
